// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for pipelined_carry_adder.
//   master: operand source + result sink (drives in_valid/a/b/cin/sub/out_ready)
//   slave : the adder (drives in_ready/out_valid/s/cout/ovf)
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract unit. The WIDTH-bit add is cut into STAGES ripple
// segments of SEG = ceil(WIDTH/STAGES) bits; each stage adds one segment with
// the carry registered by the stage before it. Operand bits not yet consumed
// ride along above the segment, finished sum bits ride along below it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every pipeline register
//   bus    slave side of pipelined_carry_adder_if:
//          in_valid/in_ready operand handshake, a, b, cin, sub (1: a+~b+~cin),
//          out_valid/out_ready result handshake, s, cout, ovf (signed overflow)
// The whole pipe advances together when the output slot is free or being
// drained (adv); otherwise everything holds. Bubbles shift like data.
module pipelined_carry_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_carry_adder_if.slave bus
);
    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || WIDTH < 2) begin : g_bad_params
        $error("pipelined_carry_adder: need WIDTH>=2 and 1<=STAGES<=WIDTH");
    end

    logic              adv;
    logic [STAGES:0]   vld_pipe;

    assign adv         = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready = adv;
    assign vld_pipe[0] = bus.in_valid & adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_pipe[STAGES:1] <= '0;
        else if (adv) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Segment bounds; with some WIDTH/STAGES mixes the tail segments are
        // empty (LO == WIDTH) and those stages only delay the finished result.
        localparam int LO = (k * SEG < WIDTH) ? k * SEG : WIDTH;
        localparam int HI = (((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH) - 1;

        logic [HI:0] s_d, s_r;   // finished sum bits [HI:0]
        logic        c_d, c_r;   // carry out of bit HI
        logic        o_d, o_r;   // signed overflow, valid once bit WIDTH-1 is done

        if (LO < WIDTH) begin : cmp
            localparam int SW = HI - LO + 1;

            logic [WIDTH-1:LO] a_i, b_i;
            logic              c_i, o_i;
            logic [SW:0]       sum;

            if (k == 0) begin : src
                // Subtract folds into the front end: invert b and the carry-in.
                assign a_i = bus.a;
                assign b_i = bus.b ^ {WIDTH{bus.sub}};
                assign c_i = bus.cin ^ bus.sub;
                assign o_i = 1'b0;
                assign s_d = sum[SW-1:0];
            end else begin : src
                assign a_i = stg[k-1].cmp.up.a_r;
                assign b_i = stg[k-1].cmp.up.b_r;
                assign c_i = stg[k-1].c_r;
                assign o_i = stg[k-1].o_r;
                assign s_d = {sum[SW-1:0], stg[k-1].s_r};
            end

            assign sum = {1'b0, a_i[HI:LO]} + {1'b0, b_i[HI:LO]} + {{SW{1'b0}}, c_i};
            assign c_d = sum[SW];
            // Carry into the MSB is recovered from the MSB sum bit itself:
            // s = a ^ b ^ c_in  =>  c_in = s ^ a ^ b.
            assign o_d = (HI == WIDTH - 1)
                       ? (sum[SW] ^ (sum[SW-1] ^ a_i[HI] ^ b_i[HI]))
                       : o_i;

            if (HI < WIDTH - 1) begin : up
                logic [WIDTH-1:HI+1] a_r, b_r;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_r <= '0;
                        b_r <= '0;
                    end else if (adv) begin
                        a_r <= a_i[WIDTH-1:HI+1];
                        b_r <= b_i[WIDTH-1:HI+1];
                    end
                end
            end
        end else begin : pass
            assign s_d = stg[k-1].s_r;
            assign c_d = stg[k-1].c_r;
            assign o_d = stg[k-1].o_r;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_r <= '0;
                c_r <= 1'b0;
                o_r <= 1'b0;
            end else if (adv) begin
                s_r <= s_d;
                c_r <= c_d;
                o_r <= o_d;
            end
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.s         = stg[STAGES-1].s_r;
    assign bus.cout      = stg[STAGES-1].c_r;
    assign bus.ovf       = stg[STAGES-1].o_r;
endmodule

// File: tb/tb_pipelined_carry_adder.sv
module tb_pipelined_carry_adder;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] es;
        logic        ec;
        logic        eo;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipelined_carry_adder_if #(.WIDTH(32)) m ();
    pipelined_carry_adder_if #(.WIDTH(10)) t ();
    pipelined_carry_adder_if #(.WIDTH(8))  u ();

    pipelined_carry_adder #(.WIDTH(32), .STAGES(4)) dut_m (.clk(clk), .rst_n(rst_n), .bus(m));
    pipelined_carry_adder #(.WIDTH(10), .STAGES(3)) dut_t (.clk(clk), .rst_n(rst_n), .bus(t));
    pipelined_carry_adder #(.WIDTH(8),  .STAGES(1)) dut_u (.clk(clk), .rst_n(rst_n), .bus(u));

    beat_t stim[$];
    beat_t expq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub,
                                    output logic [31:0] s, output logic c, output logic o);
        logic [32:0] mask, be, r;
        mask = (33'd1 << w) - 33'd1;
        be   = ({1'b0, b} ^ {33{sub}}) & mask;
        r    = {1'b0, a} + be + {32'd0, cin ^ sub};
        s    = r[31:0] & mask[31:0];
        c    = r[w];
        o    = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    task automatic add_beat(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, input logic [31:0] es, input logic ec, input logic eo);
        beat_t x;
        x.a = a; x.b = b; x.cin = cin; x.sub = sub; x.es = es; x.ec = ec; x.eo = eo;
        stim.push_back(x);
    endtask

    // Streams stim[] through the 32-bit unit, scoring results in order.
    task automatic pump(input bit rnd, input bit stall_first, input int budget, output int nout);
        int          stall = 0;
        bit          seen  = 0;
        logic [31:0] held  = '0;
        int          cyc   = 0;
        beat_t       e;
        nout = 0;
        while ((stim.size() > 0 || expq.size() > 0) && cyc < budget) begin
            if (stall_first && !seen && m.out_valid) begin
                seen  = 1;
                stall = 3;
                held  = m.s;
            end
            if (stall > 0) m.out_ready = 1'b0;
            else           m.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (stall > 0) begin
                chk("bp_in_ready", m.in_ready, 0);
                chk("bp_hold_s", m.s, held);
                chk("bp_hold_valid", m.out_valid, 1);
                stall--;
            end
            if (m.out_valid && m.out_ready) begin
                if (expq.size() == 0) chk("spurious_out", m.out_valid, 0);
                else begin
                    e = expq.pop_front();
                    nout++;
                    chk("s", m.s, e.es);
                    chk("cout", m.cout, e.ec);
                    chk("ovf", m.ovf, e.eo);
                end
            end
            if (stim.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                m.a = stim[0].a; m.b = stim[0].b; m.cin = stim[0].cin; m.sub = stim[0].sub;
                m.in_valid = 1'b1;
            end else begin
                m.in_valid = 1'b0;
            end
            #1;
            if (m.in_valid && m.in_ready) expq.push_back(stim.pop_front());
            @(negedge clk);
            cyc++;
        end
        chk("pump_budget", cyc < budget, 1);
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int    nout;
        int    vcnt;
        beat_t tv[20];
        beat_t uv[20];

        rst_n = 1'b0;
        m.in_valid = 0; m.a = 0; m.b = 0; m.cin = 0; m.sub = 0; m.out_ready = 1;
        t.in_valid = 0; t.a = 0; t.b = 0; t.cin = 0; t.sub = 0; t.out_ready = 1;
        u.in_valid = 0; u.a = 0; u.b = 0; u.cin = 0; u.sub = 0; u.out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", m.out_valid, 0);
        chk("rst_s", m.s, 0);
        chk("rst_in_ready", m.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back adds, latency 4
        m.in_valid = 1; m.a = 32'hFFFF_FFFF; m.b = 32'd1; m.cin = 0; m.sub = 0;
        @(negedge clk);
        m.a = 32'd5; m.b = 32'd7; m.cin = 1;
        @(negedge clk);
        m.in_valid = 0;
        @(negedge clk);
        chk("lat_early", m.out_valid, 0);
        @(negedge clk);
        chk("b2b0_valid", m.out_valid, 1);
        chk("b2b0_s", m.s, 32'h0);
        chk("b2b0_cout", m.cout, 1);
        chk("b2b0_ovf", m.ovf, 0);
        @(negedge clk);
        chk("b2b1_valid", m.out_valid, 1);
        chk("b2b1_s", m.s, 32'd13);
        chk("b2b1_cout", m.cout, 0);
        chk("b2b1_ovf", m.ovf, 0);
        @(negedge clk);
        chk("b2b_drain", m.out_valid, 0);

        // Reset mid-stream with a held result and a pending beat
        m.in_valid = 1; m.a = 32'd1; m.b = 32'd2; m.cin = 0; m.sub = 0;
        @(negedge clk);
        m.in_valid = 0; m.out_ready = 0;
        repeat (5) @(negedge clk);
        chk("pre_rst_valid", m.out_valid, 1);
        chk("pre_rst_s", m.s, 32'd3);
        m.in_valid = 1; m.a = 32'd9; m.b = 32'd9;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", m.out_valid, 0);
        chk("async_rst_s", m.s, 0);
        m.in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1; m.out_ready = 1;
        vcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (m.out_valid) vcnt++;
        end
        chk("no_stale_beat", vcnt, 0);
        chk("post_rst_in_ready", m.in_ready, 1);

        // Subtract and segment-boundary carries
        add_beat(32'd3,          32'd5,          0, 1, 32'hFFFF_FFFE, 0, 0);
        add_beat(32'h8000_0000,  32'd1,          0, 1, 32'h7FFF_FFFF, 1, 1);
        add_beat(32'd5,          32'd5,          1, 1, 32'hFFFF_FFFF, 0, 0);
        add_beat(32'h0000_00FF,  32'd1,          0, 0, 32'h0000_0100, 0, 0);
        add_beat(32'h0000_FFFF,  32'd1,          0, 0, 32'h0001_0000, 0, 0);
        add_beat(32'h00FF_FFFF,  32'd1,          0, 0, 32'h0100_0000, 0, 0);
        add_beat(32'h7FFF_FFFF,  32'd1,          0, 0, 32'h8000_0000, 0, 1);
        add_beat(32'h8000_0000,  32'h8000_0000,  0, 0, 32'h0000_0000, 1, 1);
        pump(0, 0, 100, nout);
        chk("dir_count", nout, 8);

        // Backpressure: 8 beats, 3 stalled cycles once results appear
        for (int i = 0; i < 8; i++)
            add_beat(i, 32'd100, 0, 0, 32'd100 + i, 0, 0);
        pump(0, 1, 100, nout);
        chk("bp_count", nout, 8);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            beat_t x;
            x.a = $urandom; x.b = $urandom;
            x.cin = 1'($urandom_range(0, 1)); x.sub = 1'($urandom_range(0, 1));
            ref_add(32, x.a, x.b, x.cin, x.sub, x.es, x.ec, x.eo);
            stim.push_back(x);
        end
        pump(1, 0, 20000, nout);
        chk("rnd_count", nout, 3000);

        // Other parameter sets: WIDTH=10/STAGES=3 and WIDTH=8/STAGES=1
        tv[0] = '{a:32'h3FF, b:32'h1, cin:0, sub:0, es:32'h000, ec:1, eo:0};
        tv[1] = '{a:32'h1FF, b:32'h1, cin:0, sub:0, es:32'h200, ec:0, eo:1};
        tv[2] = '{a:32'h00F, b:32'h1, cin:0, sub:0, es:32'h010, ec:0, eo:0};
        tv[3] = '{a:32'h0FF, b:32'h1, cin:0, sub:0, es:32'h100, ec:0, eo:0};
        uv[0] = '{a:32'h7F, b:32'h1,  cin:0, sub:0, es:32'h80, ec:0, eo:1};
        uv[1] = '{a:32'h00, b:32'h1,  cin:0, sub:1, es:32'hFF, ec:0, eo:0};
        uv[2] = '{a:32'hFF, b:32'hFF, cin:1, sub:0, es:32'hFF, ec:1, eo:0};
        uv[3] = '{a:32'h10, b:32'h10, cin:0, sub:1, es:32'h00, ec:1, eo:0};
        for (int i = 4; i < 20; i++) begin
            tv[i].a = $urandom_range(0, 1023); tv[i].b = $urandom_range(0, 1023);
            tv[i].cin = 1'($urandom_range(0, 1)); tv[i].sub = 1'($urandom_range(0, 1));
            ref_add(10, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, tv[i].es, tv[i].ec, tv[i].eo);
            uv[i].a = $urandom_range(0, 255); uv[i].b = $urandom_range(0, 255);
            uv[i].cin = 1'($urandom_range(0, 1)); uv[i].sub = 1'($urandom_range(0, 1));
            ref_add(8, uv[i].a, uv[i].b, uv[i].cin, uv[i].sub, uv[i].es, uv[i].ec, uv[i].eo);
        end
        for (int i = 0; i < 23; i++) begin
            if (i >= 3) begin
                chk("w10_valid", t.out_valid, 1);
                chk("w10_s", t.s, tv[i-3].es[9:0]);
                chk("w10_cout", t.cout, tv[i-3].ec);
                chk("w10_ovf", t.ovf, tv[i-3].eo);
            end else begin
                chk("w10_lat", t.out_valid, 0);
            end
            if (i >= 1 && i <= 20) begin
                chk("w8_valid", u.out_valid, 1);
                chk("w8_s", u.s, uv[i-1].es[7:0]);
                chk("w8_cout", u.cout, uv[i-1].ec);
                chk("w8_ovf", u.ovf, uv[i-1].eo);
            end else begin
                chk("w8_idle", u.out_valid, 0);
            end
            if (i < 20) begin
                t.in_valid = 1; t.a = tv[i].a[9:0]; t.b = tv[i].b[9:0]; t.cin = tv[i].cin; t.sub = tv[i].sub;
                u.in_valid = 1; u.a = uv[i].a[7:0]; u.b = uv[i].b[7:0]; u.cin = uv[i].cin; u.sub = uv[i].sub;
            end else begin
                t.in_valid = 0;
                u.in_valid = 0;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
